// File: rtl/cpu_types_pkg.sv
// Shared core types for the CDB result path: packet layout, requester count and indices.
package cpu_types_pkg;

  localparam int CDB_NUM_REQ  = 3;
  localparam int CDB_REQ_ALU  = 0;
  localparam int CDB_REQ_BR   = 1;
  localparam int CDB_REQ_LSU  = 2;

  localparam int CDB_PTAG_W   = 6;
  localparam int CDB_ROBTAG_W = 6;
  localparam int CDB_DATA_W   = 32;

  typedef struct packed {
    logic [CDB_PTAG_W-1:0]   ptag;
    logic [CDB_ROBTAG_W-1:0] robtag;
    logic [CDB_DATA_W-1:0]   data;
    logic                    wen;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side and broadcast-side signals of the CDB arbiter; slave = arbiter, master = core/bench.
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int PTAG_W   = 6,
  parameter int ROBTAG_W = 6,
  parameter int DATA_W   = 32
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                               flush_i;
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0][PTAG_W-1:0]     req_ptag_i;
  logic [NUM_REQ-1:0][ROBTAG_W-1:0]   req_robtag_i;
  logic [NUM_REQ-1:0][DATA_W-1:0]     req_data_i;
  logic [NUM_REQ-1:0]                 req_wen_i;

  logic                               cdb_valid_o;
  logic [PTAG_W-1:0]                  cdb_ptag_o;
  logic [ROBTAG_W-1:0]                cdb_robtag_o;
  logic [DATA_W-1:0]                  cdb_data_o;
  logic                               cdb_wen_o;
  logic [SRC_W-1:0]                   cdb_src_o;

  modport master (
    output flush_i, req_valid_i, req_ptag_i, req_robtag_i, req_data_i, req_wen_i,
    input  req_ready_o, cdb_valid_o, cdb_ptag_o, cdb_robtag_o, cdb_data_o, cdb_wen_o, cdb_src_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_ptag_i, req_robtag_i, req_data_i, req_wen_i,
    output req_ready_o, cdb_valid_o, cdb_ptag_o, cdb_robtag_o, cdb_data_o, cdb_wen_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_hold_slot.sv
// One-entry result holding register; flush beats accept, accept beats grant (reload-on-grant).
module cdb_hold_slot
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        grant,
  input  logic        flush,
  input  cdb_packet_t din,
  output logic        full,
  output cdb_packet_t dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
      dout <= din;
    end else if (grant) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one grant per cycle over per-requester hold slots, registered broadcast 2 cycles after accept;
// no downstream backpressure, requesters stall only on a full ungranted slot. CDB_ARB_FIXED_PRIO_EN selects fixed priority.
module cdb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NUM_REQ  = CDB_NUM_REQ,
  parameter int PTAG_W   = CDB_PTAG_W,
  parameter int ROBTAG_W = CDB_ROBTAG_W,
  parameter int DATA_W   = CDB_DATA_W
)(
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slot_full;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  cdb_packet_t        slot_pkt [NUM_REQ];
  cdb_packet_t        sel_pkt;
  logic               gnt_any;
  logic [SRC_W-1:0]   gnt_idx;

  logic               valid_q;
  logic               wen_q;
  logic [PTAG_W-1:0]  ptag_q;
  logic [ROBTAG_W-1:0] robtag_q;
  logic [DATA_W-1:0]  data_q;
  logic [SRC_W-1:0]   src_q;

  // Ready ignores valid so upstream can compute it without a combinational loop.
  assign bus.req_ready_o = ~slot_full | grant | {NUM_REQ{bus.flush_i}};
  assign accept          = bus.req_valid_i & bus.req_ready_o;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    cdb_hold_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .accept (accept[i]),
      .grant  (grant[i]),
      .flush  (bus.flush_i),
      .din    ('{ptag:   bus.req_ptag_i[i],
                 robtag: bus.req_robtag_i[i],
                 data:   bus.req_data_i[i],
                 wen:    bus.req_wen_i[i]}),
      .full   (slot_full[i]),
      .dout   (slot_pkt[i])
    );
  end

`ifdef CDB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (slot_full[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(i);
      end
    end
    if (bus.flush_i) gnt_any = 1'b0;
  end
`else
  logic [SRC_W-1:0] rr_ptr;

  // Walk the search order backwards so the earliest candidate after rr_ptr is the last written.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (slot_full[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
    if (bus.flush_i) gnt_any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`endif

  always_comb begin
    grant   = '0;
    sel_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = gnt_any && (gnt_idx == SRC_W'(i));
      if (grant[i]) sel_pkt = slot_pkt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      wen_q    <= 1'b0;
      ptag_q   <= '0;
      robtag_q <= '0;
      data_q   <= '0;
      src_q    <= '0;
    end else if (gnt_any) begin
      valid_q  <= 1'b1;
      wen_q    <= sel_pkt.wen;
      ptag_q   <= sel_pkt.ptag;
      robtag_q <= sel_pkt.robtag;
      data_q   <= sel_pkt.data;
      src_q    <= gnt_idx;
    end else begin
      valid_q  <= 1'b0;
      wen_q    <= 1'b0;
    end
  end

  assign bus.cdb_valid_o  = valid_q;
  assign bus.cdb_wen_o    = wen_q;
  assign bus.cdb_ptag_o   = ptag_q;
  assign bus.cdb_robtag_o = robtag_q;
  assign bus.cdb_data_o   = data_q;
  assign bus.cdb_src_o    = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed + randomized bench for cdb_arbiter against a slot/queue-level reference model.
module tb_cdb_arbiter;
  import cpu_types_pkg::*;

  localparam int N = CDB_NUM_REQ;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .PTAG_W(CDB_PTAG_W), .ROBTAG_W(CDB_ROBTAG_W), .DATA_W(CDB_DATA_W)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .PTAG_W(CDB_PTAG_W), .ROBTAG_W(CDB_ROBTAG_W), .DATA_W(CDB_DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: which slots hold a result, what they hold, where the search starts next.
  bit          m_full [N];
  cdb_packet_t m_slot [N];
  int          m_ptr;
  bit          e_valid;
  cdb_packet_t e_pkt;
  int          e_src;
  cdb_packet_t drv [N];
  int          obs_cnt [N];
  int          nvalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_slot[i] = '0;
    end
    m_ptr   = 0;
    e_valid = 1'b0;
    e_pkt   = '0;
    e_src   = 0;
  endtask

  function automatic int model_pick(input bit f);
    if (f) return -1;
`ifdef CDB_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m_full[i]) return i;
`else
    for (int k = 0; k < N; k++) if (m_full[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic check_out();
    chk("cdb_valid", 64'(bus.cdb_valid_o), 64'(e_valid));
    chk("cdb_wen", 64'(bus.cdb_wen_o), 64'(e_valid && e_pkt.wen));
    if (e_valid) begin
      chk("cdb_ptag", 64'(bus.cdb_ptag_o), 64'(e_pkt.ptag));
      chk("cdb_robtag", 64'(bus.cdb_robtag_o), 64'(e_pkt.robtag));
      chk("cdb_data", 64'(bus.cdb_data_o), 64'(e_pkt.data));
      chk("cdb_src", 64'(bus.cdb_src_o), 64'(e_src));
    end
  endtask

  // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs just after.
  task automatic cycle(input logic [N-1:0] v, input bit f, input bit rnd);
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] acc;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        drv[i].ptag   = CDB_PTAG_W'($urandom);
        drv[i].robtag = CDB_ROBTAG_W'($urandom);
        drv[i].data   = CDB_DATA_W'($urandom);
        drv[i].wen    = 1'($urandom);
      end
      bus.req_ptag_i[i]   = drv[i].ptag;
      bus.req_robtag_i[i] = drv[i].robtag;
      bus.req_data_i[i]   = drv[i].data;
      bus.req_wen_i[i]    = drv[i].wen;
    end
    bus.req_valid_i = v;
    bus.flush_i     = f;
    #1;
    g = model_pick(f);
    for (int i = 0; i < N; i++) exp_rdy[i] = !m_full[i] || (g == i) || f;
    chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
    acc = v & exp_rdy;
    @(posedge clk);
    if (f) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      e_valid = 1'b0;
    end else begin
      if (g >= 0) begin
        e_valid = 1'b1;
        e_pkt   = m_slot[g];
        e_src   = g;
        m_ptr   = (g + 1) % N;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          m_full[i] = 1'b1;
          m_slot[i] = drv[i];
        end else if (g == i) begin
          m_full[i] = 1'b0;
        end
      end
    end
    #1;
    check_out();
  endtask

  initial begin
    bus.flush_i      = 1'b0;
    bus.req_valid_i  = '0;
    bus.req_ptag_i   = '0;
    bus.req_robtag_i = '0;
    bus.req_data_i   = '0;
    bus.req_wen_i    = '0;
    for (int i = 0; i < N; i++) drv[i] = '0;
    model_reset();

    // Held in reset: ready all ones, bus idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.req_ready_o), 64'({N{1'b1}}));
    chk("rst_valid", 64'(bus.cdb_valid_o), 64'(0));
    chk("rst_src", 64'(bus.cdb_src_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    repeat (10) cycle('0, 1'b0, 1'b1);

    // Single ALU result: visible two edges after the accept.
    drv[CDB_REQ_ALU] = '{ptag: 6'd5, robtag: 6'd2, data: 32'hDEAD_BEEF, wen: 1'b1};
    cycle(3'b001, 1'b0, 1'b0);
    chk("alu_lat1_valid", 64'(bus.cdb_valid_o), 64'(0));
    cycle('0, 1'b0, 1'b1);
    chk("alu_valid", 64'(bus.cdb_valid_o), 64'(1));
    chk("alu_ptag", 64'(bus.cdb_ptag_o), 64'(5));
    chk("alu_robtag", 64'(bus.cdb_robtag_o), 64'(2));
    chk("alu_data", 64'(bus.cdb_data_o), 64'(32'hDEAD_BEEF));
    chk("alu_src", 64'(bus.cdb_src_o), 64'(CDB_REQ_ALU));
    chk("alu_wen", 64'(bus.cdb_wen_o), 64'(1));
    cycle('0, 1'b0, 1'b1);

    // All slots kept full: fair share over N*2 grants.
    cycle({N{1'b1}}, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) obs_cnt[i] = 0;
    repeat (2 * N) begin
      cycle({N{1'b1}}, 1'b0, 1'b1);
      if (bus.cdb_valid_o && int'(bus.cdb_src_o) < N) obs_cnt[bus.cdb_src_o]++;
    end
`ifdef CDB_ARB_FIXED_PRIO_EN
    chk("fp_alu_share", 64'(obs_cnt[CDB_REQ_ALU]), 64'(2 * N));
    chk("fp_br_share", 64'(obs_cnt[CDB_REQ_BR]), 64'(0));
    chk("fp_lsu_share", 64'(obs_cnt[CDB_REQ_LSU]), 64'(0));
`else
    chk("rr_alu_share", 64'(obs_cnt[CDB_REQ_ALU]), 64'(2));
    chk("rr_br_share", 64'(obs_cnt[CDB_REQ_BR]), 64'(2));
    chk("rr_lsu_share", 64'(obs_cnt[CDB_REQ_LSU]), 64'(2));
`endif
    repeat (N + 1) cycle('0, 1'b0, 1'b1);

    // ALU streaming: one broadcast every cycle after the first fill.
    cycle(3'b001, 1'b0, 1'b1);
    nvalid = 0;
    repeat (7) begin
      cycle(3'b001, 1'b0, 1'b1);
      if (bus.cdb_valid_o) nvalid++;
    end
    chk("stream_count", 64'(nvalid), 64'(7));
    repeat (2) cycle('0, 1'b0, 1'b1);

    // Flush with slots 1,2 busy and an LSU result offered in the flush cycle.
    cycle(3'b110, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    cycle(3'b100, 1'b1, 1'b1);
    chk("flush_valid", 64'(bus.cdb_valid_o), 64'(0));
    nvalid = 0;
    repeat (4) begin
      cycle('0, 1'b0, 1'b1);
      if (bus.cdb_valid_o) nvalid++;
    end
    chk("flush_no_leak", 64'(nvalid), 64'(0));

    // Asynchronous reset mid-cycle while every slot is full.
    cycle({N{1'b1}}, 1'b0, 1'b1);
    cycle({N{1'b1}}, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.cdb_valid_o), 64'(0));
    chk("arst_wen", 64'(bus.cdb_wen_o), 64'(0));
    chk("arst_ptag", 64'(bus.cdb_ptag_o), 64'(0));
    chk("arst_robtag", 64'(bus.cdb_robtag_o), 64'(0));
    chk("arst_data", 64'(bus.cdb_data_o), 64'(0));
    chk("arst_src", 64'(bus.cdb_src_o), 64'(0));
    chk("arst_ready", 64'(bus.req_ready_o), 64'({N{1'b1}}));
    model_reset();
    bus.req_valid_i = '0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic with occasional flushes.
    repeat (400) cycle(N'($urandom), ($urandom_range(0, 15) == 0), 1'b1);
    repeat (N + 1) cycle('0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
